psum_drain_ctrl: RTL and testbench
==================================

// Module: psum_drain_ctrl
// PURPOSE
//  Drains the per-column psum FIFOs (one asyn_fifo per array column, read side on clk) into the psum SRAM.
//  Runs one row at a time: when every column FIFO is non-empty, it pops all columns together.
//  The popped row is packed, optionally ReLU'd, and written to SRAM at base_addr + row index.
//  Sequences a job of num_rows rows per start pulse; sits between the PE-array output FIFOs and the psum SRAM.
// PARAMETERS
//  col      8   number of array columns / FIFOs drained in lockstep
//  bw       4   activation/weight width
//  bw_psum  12  psum width (2*bw+4), signed two's complement
//  addr_w   4   psum SRAM address width (depth 2**addr_w rows)
// PORTS
//  clk           in   1               single clock (FIFO rd_clk domain)
//  reset         in   1               synchronous, active-high reset
//  start         in   1               1-cycle pulse; launches a job, ignored while busy
//  num_rows      in   addr_w+1        rows in job, sampled at start; 0 => immediate done
//  base_addr     in   addr_w          first SRAM row address, sampled at start
//  relu_en       in   1               sampled at start; 1 => negative psums written as 0
//  fifo_empty    in   col             per-column FIFO empty flags
//  fifo_rd_en    out  col             per-column pop strobe; all bits always equal
//  fifo_rd_data  in   col*bw_psum     column c at [c*bw_psum +: bw_psum]; valid 1 cycle after pop
//  sram_wen      out  1               SRAM write strobe, 1 cycle per row
//  sram_addr     out  addr_w          SRAM write address
//  sram_wdata    out  col*bw_psum     packed row, same column order as fifo_rd_data
//  busy          out  1               high from cycle after start until done
//  done          out  1               1-cycle pulse when last row written
// BEHAVIOUR
//  Reset (sync): state IDLE; all outputs 0; counters and sampled config cleared.
//  States:
//   IDLE  -> RUN on start with num_rows!=0. start with num_rows==0 pulses done next cycle and stays IDLE.
//   RUN   pop when &(~fifo_empty) && issued<num_rows.
//         fifo_rd_en = {col{pop}}, combinational from state/flags; never asserted if any column is empty.
//   RUN   -> FLUSH in the cycle the last pop issues (issued==num_rows-1 && pop).
//   FLUSH -> IDLE the next cycle; the last write occurs in that cycle and done pulses together with it.
//  Pipeline: pop at cycle t => capture fifo_rd_data and assert sram_wen at t+1, registered outputs.
//   Back-to-back pops allowed; peak throughput is 1 row/cycle.
//  Address: sram_addr = base_addr + written_cnt, modulo 2**addr_w; wraps silently past the top.
//  ReLU: per column, if relu_en && data[bw_psum-1] then 0 else data; no other arithmetic or width change.
//  Partial-empty: if any column is empty, no column pops; the row stalls without limit.
//   Column skew between FIFOs is absorbed by the FIFOs themselves.
//  Simultaneous: a start while busy is dropped (no queueing). done and a new start in the same cycle: start ignored.
//  busy: 1 in RUN/FLUSH, 0 in IDLE, including the cycle done pulses.
//  Reset mid-job: abort immediately. Rows already written stay in SRAM.
//   FIFO contents are not flushed; that is the FIFO's own reset.
//  Counters: issued and written are addr_w+1 bits; num_rows==2**addr_w is legal (full SRAM).
// STRUCTURE
//  Shared package (psum_pkg): BW, BW_PSUM=2*BW+4, COL, state enum {IDLE,RUN,FLUSH}.
//  One sub-module: psum_relu (combinational, per-column clamp, instantiated col times via generate).
//  Everything else is flat: FSM, two counters, config regs, output pipeline regs.
// TESTING
//  1 reset, start num_rows=4 base=2, all FIFOs pre-filled with 4 rows -> pops at t1..t4, wen t2..t5,
//    addr 2,3,4,5, done at t5, busy t1..t5.
//  2 column 5 empty for 3 cycles mid-job -> no fifo_rd_en bit asserts while empty; rows stay intact and in order.
//  3 relu_en=1, column data -7 (0xFF9) and +9 -> wdata fields 0x000 and 0x009; relu_en=0 -> 0xFF9 kept.
//  4 base=14, num_rows=4 -> addr 14,15,0,1; num_rows=16 -> 16 writes, done once.
//  5 start num_rows=0 -> done next cycle, no pop, no wen. start pulsed while busy -> ignored, job count unchanged.
//  6 reset asserted after 2 of 5 rows -> next cycle all outputs 0, IDLE; a new start then runs a clean job.

Source files
------------

// File: rtl/psum_pkg.sv
// ----------------------------------------------------------------------------
// psum_pkg
// Shared constants and types for the psum drain path.
//   BW       activation/weight width
//   BW_PSUM  psum width (2*BW+4), signed two's complement
//   COL      number of array columns / psum FIFOs drained in lockstep
//   ADDR_W   psum SRAM address width (depth 2**ADDR_W rows)
//   state_t  drain controller states
// ----------------------------------------------------------------------------
package psum_pkg;

    localparam int BW      = 4;
    localparam int BW_PSUM = 2 * BW + 4;
    localparam int COL     = 8;
    localparam int ADDR_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/psum_relu.sv
// ----------------------------------------------------------------------------
// psum_relu
// Combinational per-column clamp: negative psums become 0 when enabled,
// otherwise the value passes through unchanged (no width change).
// Ports:
//   en    in   1        clamp enable
//   din   in   BW_PSUM  signed psum
//   dout  out  BW_PSUM  clamped psum
// ----------------------------------------------------------------------------
module psum_relu
    import psum_pkg::*;
(
    input  logic               en,
    input  logic [BW_PSUM-1:0] din,
    output logic [BW_PSUM-1:0] dout
);

    assign dout = (en && din[BW_PSUM-1]) ? '0 : din;

endmodule

// File: rtl/psum_drain_ctrl.sv
// ----------------------------------------------------------------------------
// psum_drain_ctrl
// Drains the per-column psum FIFOs into the psum SRAM one row at a time.
// A row is popped from all columns together once every column is non-empty,
// optionally ReLU'd, and written at base_addr + row index (mod SRAM depth).
//
// State table:
//   IDLE  | waiting for start; config sampled when a job is accepted
//   RUN   | popping rows whenever all FIFOs are non-empty
//   FLUSH | last row is being written; done pulses here
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          1-cycle job launch (ignored while busy or while done pulses)
//   num_rows       rows in job (0 => immediate done), sampled at start
//   base_addr      first SRAM row, sampled at start
//   relu_en        clamp negatives to 0, sampled at start
//   fifo_empty     per-column empty flags
//   fifo_rd_en     per-column pop strobe (all bits equal)
//   fifo_rd_data   popped row, valid the cycle after the pop
//   sram_wen       write strobe, one cycle per row
//   sram_addr      write address
//   sram_wdata     packed (optionally clamped) row
//   busy           high in RUN/FLUSH
//   done           1-cycle pulse with the last write (or after a 0-row start)
// ----------------------------------------------------------------------------
module psum_drain_ctrl
    import psum_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W:0]        num_rows,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   relu_en,
    input  logic [COL-1:0]         fifo_empty,
    output logic [COL-1:0]         fifo_rd_en,
    input  logic [COL*BW_PSUM-1:0] fifo_rd_data,
    output logic                   sram_wen,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [COL*BW_PSUM-1:0] sram_wdata,
    output logic                   busy,
    output logic                   done
);

    state_t state, state_nxt;

    logic [ADDR_W:0]        num_rows_q;
    logic [ADDR_W:0]        issued;
    logic [ADDR_W:0]        written;
    logic [ADDR_W-1:0]      base_q;
    logic                   relu_q;
    logic                   zero_done_q;
    logic                   wen_q;
    logic                   pop;
    logic                   accept;
    logic                   last_pop;
    logic [COL*BW_PSUM-1:0] relu_row;

    // A start coinciding with the zero-row done pulse is dropped as well.
    assign accept   = (state == IDLE) && start && !zero_done_q;
    assign pop      = (state == RUN) && (&(~fifo_empty)) && (issued < num_rows_q);
    assign last_pop = pop && ((issued + (ADDR_W+1)'(1)) == num_rows_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (num_rows != '0)) state_nxt = RUN;
            RUN:     if (last_pop)                   state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        fifo_rd_en = {COL{pop}};
        busy       = (state != IDLE);
        done       = (state == FLUSH) || zero_done_q;
    end

    // Config, counters and write pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            num_rows_q  <= '0;
            base_q      <= '0;
            relu_q      <= 1'b0;
            issued      <= '0;
            written     <= '0;
            zero_done_q <= 1'b0;
            wen_q       <= 1'b0;
        end else begin
            zero_done_q <= accept && (num_rows == '0);
            wen_q       <= pop;
            if (accept) begin
                num_rows_q <= num_rows;
                base_q     <= base_addr;
                relu_q     <= relu_en;
                issued     <= '0;
                written    <= '0;
            end else begin
                if (pop)   issued  <= issued + 1'b1;
                if (wen_q) written <= written + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < COL; c++) begin : g_relu
        psum_relu u_relu (
            .en   (relu_q),
            .din  (fifo_rd_data[c*BW_PSUM +: BW_PSUM]),
            .dout (relu_row[c*BW_PSUM +: BW_PSUM])
        );
    end

    // The FIFO presents popped data in the cycle after the pop, which is the
    // same cycle the write strobe is up, so the row is forwarded straight
    // through the clamp. Address and data are held at 0 between writes.
    assign sram_wen   = wen_q;
    assign sram_addr  = wen_q ? ADDR_W'({1'b0, base_q} + written) : '0;
    assign sram_wdata = wen_q ? relu_row : '0;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
module tb_psum_drain_ctrl;
    import psum_pkg::*;

    localparam int RW = COL * BW_PSUM;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   num_rows;
    logic [ADDR_W-1:0] base_addr;
    logic              relu_en;
    logic [COL-1:0]    fifo_empty;
    logic [COL-1:0]    fifo_rd_en;
    logic [RW-1:0]     fifo_rd_data;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [RW-1:0]     sram_wdata;
    logic              busy;
    logic              done;

    psum_drain_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_rows     (num_rows),
        .base_addr    (base_addr),
        .relu_en      (relu_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model (one per column) ----------------
    logic [BW_PSUM-1:0] mem [COL][1024];
    int                 wptr [COL];
    int                 rptr [COL];
    logic [COL-1:0]     mask;

    always_comb begin
        fifo_empty = '0;
        for (int c = 0; c < COL; c++)
            fifo_empty[c] = (rptr[c] == wptr[c]) || mask[c];
    end

    always @(posedge clk) begin
        for (int c = 0; c < COL; c++) begin
            if (reset) begin
                rptr[c] <= wptr[c];
            end else if (fifo_rd_en[c]) begin
                fifo_rd_data[c*BW_PSUM +: BW_PSUM] <= mem[c][rptr[c]];
                rptr[c] <= rptr[c] + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected row for a write: every column of the idx-th pushed row,
    // negatives zeroed when the job has ReLU enabled.
    function automatic logic [RW-1:0] model_row(input int idx, input bit r);
        logic [RW-1:0]      row;
        logic [BW_PSUM-1:0] v;
        row = '0;
        for (int c = 0; c < COL; c++) begin
            v = mem[c][idx];
            if (r && v[BW_PSUM-1]) v = '0;
            row[c*BW_PSUM +: BW_PSUM] = v;
        end
        return row;
    endfunction

    // job description for the model
    int                exp_n = 0;
    logic [ADDR_W-1:0] exp_base = '0;
    bit                exp_relu = 1'b0;
    int                job_seq = 0;

    int                seen_seq = -1;
    int                k = 0;
    int                mi = 0;
    int                wen_cnt = 0;
    int                done_cnt = 0;
    int                pop_cnt = 0;
    logic [ADDR_W-1:0] addr_log [4096];
    logic [RW-1:0]     data_log [4096];

    always @(negedge clk) begin
        if (reset) begin
            mi = wptr[0];
        end else begin
            if (job_seq != seen_seq) begin
                seen_seq = job_seq;
                k = 0;
            end
            if (fifo_rd_en != '0) begin
                pop_cnt++;
                chk("rd_en_lockstep", fifo_rd_en, {COL{1'b1}});
                chk("pop_while_empty", fifo_empty, '0);
            end
            if (sram_wen) begin
                addr_log[wen_cnt] = sram_addr;
                data_log[wen_cnt] = sram_wdata;
                wen_cnt++;
                chk("write_within_job", k < exp_n, 1'b1);
                chk("sram_addr", sram_addr, ADDR_W'(exp_base + ADDR_W'(k)));
                chk("sram_wdata", sram_wdata, model_row(mi, exp_relu));
                k++;
                mi++;
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [RW-1:0] row);
        for (int c = 0; c < COL; c++) begin
            mem[c][wptr[c]] = row[c*BW_PSUM +: BW_PSUM];
            wptr[c] = wptr[c] + 1;
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] row;
        for (int c = 0; c < COL; c++)
            row[c*BW_PSUM +: BW_PSUM] = BW_PSUM'($urandom);
        return row;
    endfunction

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_row(rand_row());
    endtask

    task automatic launch(input int n, input int base, input bit r);
        exp_n     = n;
        exp_base  = ADDR_W'(base);
        exp_relu  = r;
        job_seq++;
        num_rows  = (ADDR_W+1)'(n);
        base_addr = ADDR_W'(base);
        relu_en   = r;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int max, input bit stall);
        for (int i = 0; i < max && done_cnt == d0; i++) begin
            if (stall)
                mask = ($urandom_range(0, 3) == 0) ? COL'(1 << $urandom_range(0, COL-1)) : '0;
            tick();
        end
        mask = '0;
        tick();
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic run_job(input int n, input int base, input bit r, input bit stall);
        int w0, d0;
        w0 = wen_cnt;
        d0 = done_cnt;
        launch(n, base, r);
        wait_done(d0, 400, stall);
        chk("rows_written", wen_cnt - w0, n);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rd_en"}, fifo_rd_en, '0);
        chk({name, "_wen"},   sram_wen, 1'b0);
        chk({name, "_addr"},  sram_addr, '0);
        chk({name, "_wdata"}, sram_wdata, '0);
        chk({name, "_busy"},  busy, 1'b0);
        chk({name, "_done"},  done, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w0, d0, p0;
        logic [RW-1:0] row;
        logic [COL-1:0]    t_rd   [1:6];
        logic              t_wen  [1:6];
        logic [ADDR_W-1:0] t_addr [1:6];
        logic              t_done [1:6];
        logic              t_busy [1:6];

        for (int c = 0; c < COL; c++) begin
            wptr[c] = 0;
            rptr[c] = 0;
        end
        mask = '0; start = 1'b0; num_rows = '0; base_addr = '0; relu_en = 1'b0;
        fifo_rd_data = '0;
        reset = 1'b1;
        tick(); tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // 1: 4 rows at base 2, cycle-exact
        t_rd   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        t_wen  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        t_addr = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        t_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        push_rand(4);
        w0 = wen_cnt;
        launch(4, 2, 1'b0);
        for (int t = 1; t <= 6; t++) begin
            chk($sformatf("t1_rd_en_c%0d", t), fifo_rd_en, t_rd[t]);
            chk($sformatf("t1_wen_c%0d", t),   sram_wen,   t_wen[t]);
            chk($sformatf("t1_addr_c%0d", t),  sram_addr,  t_addr[t]);
            chk($sformatf("t1_done_c%0d", t),  done,       t_done[t]);
            chk($sformatf("t1_busy_c%0d", t),  busy,       t_busy[t]);
            tick();
        end
        chk("t1_rows", wen_cnt - w0, 4);

        // 2: column 5 empty for 3 cycles mid-job
        push_rand(6);
        w0 = wen_cnt;
        d0 = done_cnt;
        launch(6, 7, 1'b0);
        tick();
        mask = 8'b0010_0000;
        tick(); tick(); tick();
        mask = '0;
        wait_done(d0, 100, 1'b0);
        chk("t2_rows", wen_cnt - w0, 6);

        // 3: ReLU on and off with -7 / +9 in columns 0 / 1
        row = rand_row();
        row[0 +: BW_PSUM]       = 12'hFF9;
        row[BW_PSUM +: BW_PSUM] = 12'h009;
        push_row(row);
        w0 = wen_cnt;
        run_job(1, 0, 1'b1, 1'b0);
        chk("t3_relu_neg", data_log[w0][0 +: BW_PSUM], 12'h000);
        chk("t3_relu_pos", data_log[w0][BW_PSUM +: BW_PSUM], 12'h009);
        push_row(row);
        w0 = wen_cnt;
        run_job(1, 0, 1'b0, 1'b0);
        chk("t3_norelu_neg", data_log[w0][0 +: BW_PSUM], 12'hFF9);

        // 4: address wrap and full-depth job
        push_rand(4);
        w0 = wen_cnt;
        run_job(4, 14, 1'b0, 1'b0);
        chk("t4_addr0", addr_log[w0],   4'd14);
        chk("t4_addr1", addr_log[w0+1], 4'd15);
        chk("t4_addr2", addr_log[w0+2], 4'd0);
        chk("t4_addr3", addr_log[w0+3], 4'd1);
        push_rand(16);
        run_job(16, 5, 1'b1, 1'b0);

        // 5a: zero-row job, and a start landing on its done pulse
        push_rand(2);
        w0 = wen_cnt;
        p0 = pop_cnt;
        launch(0, 3, 1'b0);
        chk("t5_zero_done", done, 1'b1);
        chk("t5_zero_busy", busy, 1'b0);
        num_rows = 2; base_addr = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_done_gone", done, 1'b0);
        chk("t5_start_on_done_ignored", busy, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_zero_no_wen", wen_cnt - w0, 0);
        chk("t5_zero_no_pop", pop_cnt - p0, 0);
        run_job(2, 1, 1'b0, 1'b0);

        // 5b: start while busy is dropped
        push_rand(5);
        w0 = wen_cnt;
        d0 = done_cnt;
        launch(5, 3, 1'b0);
        mask = 8'h01;
        tick(); tick();
        num_rows = 2; base_addr = 4'd9; relu_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        mask = '0;
        wait_done(d0, 100, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_busy_start_rows", wen_cnt - w0, 5);
        chk("t5_busy_start_done", done_cnt - d0, 1);

        // 6: reset after 2 of 5 rows
        push_rand(5);
        w0 = wen_cnt;
        launch(5, 0, 1'b0);
        for (int i = 0; i < 50 && wen_cnt < w0 + 2; i++) tick();
        chk("t6_two_written", wen_cnt - w0, 2);
        reset = 1'b1;
        tick();
        chk_all_zero("t6_after_reset");
        reset = 1'b0;
        tick();
        push_rand(3);
        run_job(3, 6, 1'b1, 1'b0);

        // randomized jobs with random column stalls
        for (int j = 0; j < 12; j++) begin
            int n;
            n = $urandom_range(1, 16);
            push_rand(n);
            run_job(n, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
